// File: rtl/logica_activacion_pkg.sv
// logica_activacion_pkg: shared types and constants for the multi-zone activation logic
package logica_activacion_pkg;
  typedef enum logic [1:0] {V_OFF = 2'd0, V_ON = 2'd1, V_HOLD = 2'd2} vent_estado_t;
  localparam logic ENCENDIDO = 1'b1;
  localparam logic APAGADO = 1'b0;
  localparam int BIT_DEBIL = 1;
  localparam int BIT_FUERTE = 0;
endpackage

// File: rtl/logica_activacion_zonas_zona.sv
// zona_activacion: one zone's confirmation counter, alarm register and ventilation FSM with hold timer
// Optional alarm latching with ack under LOGICA_ACTIVACION_LATCH_EN.
module zona_activacion
  import logica_activacion_pkg::*;
#(
  parameter int CONFIRM = 3,
  parameter int HOLD_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] alerta,
  input  logic       presencia,
  input  logic       ignicion,
  input  logic       activar_decidir,
  input  logic       ack,
  output logic       alarma,
  output logic       ventilacion,
  output logic       peligro_z
);
  localparam int CW = $clog2(CONFIRM + 1);
  localparam int TW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CONFIRM);
  localparam logic [TW-1:0] TLOAD = TW'(HOLD_CYCLES - 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tmr;
  vent_estado_t est;
  logic inhibe, hay, fuerte, conf, fija, alarma_nx;
  always_comb begin
    inhibe = ignicion | ~presencia;
    fuerte = alerta[BIT_FUERTE];
    hay = alerta[BIT_DEBIL] | fuerte;
    cnt_nx = (inhibe | ~hay) ? '0 : (cnt == CMAX) ? CMAX : cnt + 1'b1;
    conf = cnt_nx == CMAX;
    fija = ~inhibe & hay & conf;
    peligro_z = fija;
`ifdef LOGICA_ACTIVACION_LATCH_EN
    alarma_nx = (activar_decidir & inhibe) ? APAGADO :
                (activar_decidir & fija) ? ENCENDIDO :
                ack ? APAGADO : alarma;
`else
    alarma_nx = activar_decidir ? fija : alarma;
`endif
  end
`ifndef LOGICA_ACTIVACION_LATCH_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif
  // ventilacion is registered alongside each state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      alarma <= APAGADO;
      est <= V_OFF;
      tmr <= '0;
      ventilacion <= APAGADO;
    end else begin
      alarma <= alarma_nx;
      if (activar_decidir) cnt <= cnt_nx;
      if (activar_decidir && inhibe) begin
        est <= V_OFF;
        tmr <= '0;
        ventilacion <= APAGADO;
      end else begin
        case (est)
          V_OFF: if (activar_decidir && fuerte && conf) begin
            est <= V_ON;
            ventilacion <= ENCENDIDO;
          end
          V_ON: if (activar_decidir && !fuerte) begin
            est <= V_HOLD;
            tmr <= TLOAD;
          end
          V_HOLD: if (activar_decidir && fuerte && conf) begin
            est <= V_ON;
            tmr <= '0;
          end else if (tmr == '0) begin
            est <= V_OFF;
            ventilacion <= APAGADO;
          end else begin
            tmr <= tmr - 1'b1;
          end
          default: begin
            est <= V_OFF;
            tmr <= '0;
            ventilacion <= APAGADO;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/logica_activacion_zonas.sv
// logica_activacion_zonas: NUM_ZONAS independent activation zones with combined danger flag
// Alarm latching with ack is enabled by defining LOGICA_ACTIVACION_LATCH_EN.
module logica_activacion_zonas
  import logica_activacion_pkg::*;
#(
  parameter int NUM_ZONAS = 4,
  parameter int CONFIRM = 3,
  parameter int HOLD_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_ZONAS-1:0] alerta,
  input  logic [NUM_ZONAS-1:0]   presencia,
  input  logic                   ignicion,
  input  logic                   activar_decidir,
  input  logic                   ack,
  output logic [NUM_ZONAS-1:0]   alarma,
  output logic [NUM_ZONAS-1:0]   ventilacion,
  output logic                   peligro
);
  logic [NUM_ZONAS-1:0] peligro_v;
  for (genvar z = 0; z < NUM_ZONAS; z++) begin : g_zona
    zona_activacion #(
      .CONFIRM(CONFIRM),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_zona (
      .clk(clk),
      .rst(rst),
      .alerta(alerta[2*z+1:2*z]),
      .presencia(presencia[z]),
      .ignicion(ignicion),
      .activar_decidir(activar_decidir),
      .ack(ack),
      .alarma(alarma[z]),
      .ventilacion(ventilacion[z]),
      .peligro_z(peligro_v[z])
    );
  end
  assign peligro = |peligro_v;
endmodule
